// File: rtl/bram_loader_pkg.sv
// Shared types and helpers for the block-RAM stream loader: FSM states,
// error codes and the payload checksum step.
package bram_loader_pkg;

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_HDR2,
      S_HDR3,
      S_DATA,
      S_CSUM,
      S_VERIFY,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_LEN    = 2'd1,
      ERR_CSUM   = 2'd2,
      ERR_VERIFY = 2'd3
   } err_t;

   localparam int HDR_BYTES = 4;

   function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] dataByte);
      return sum + dataByte;
   endfunction

endpackage

// File: rtl/loader_readback.sv
// Readback checker: walks start..start+N-1 one address per cycle, follows the
// two-cycle RAM read latency with a valid pipe and compares the summed data.
module loader_readback
   import bram_loader_pkg::*;
#(
   parameter int AWID = 12
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [AWID-1:0] startAddr_i,
   input  logic [16:0]     count_i,
   input  logic [7:0]      expected_i,
   input  logic [7:0]      rdData_i,
   output logic [AWID-1:0] rdAddr_o,
   output logic            busy_o,
   output logic            mismatch_o,
   output logic            fin_o
);

   logic [AWID-1:0] addr_q, addr_d;
   logic [16:0]     remain_q, remain_d;
   logic [1:0]      valid_q, valid_d;
   logic [7:0]      sum_q, sum_d;
   logic            issue;

   always_comb begin
      issue    = (remain_q != '0);
      addr_d   = addr_q;
      remain_d = remain_q;
      sum_d    = sum_q;
      valid_d  = {valid_q[0], issue};
      if (valid_q[1]) sum_d = csum_add(sum_q, rdData_i);
      if (start_i) begin
         addr_d   = startAddr_i;
         remain_d = count_i;
         sum_d    = '0;
         valid_d  = '0;
      end else if (issue) begin
         addr_d   = addr_q + AWID'(1);
         remain_d = remain_q - 17'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q   <= '0;
         remain_q <= '0;
         valid_q  <= '0;
         sum_q    <= '0;
      end else begin
         addr_q   <= addr_d;
         remain_q <= remain_d;
         valid_q  <= valid_d;
         sum_q    <= sum_d;
      end
   end

   // Reads are contiguous, so the last return is the only cycle with stage 1 valid and stage 0 empty.
   assign rdAddr_o   = addr_q;
   assign busy_o     = issue;
   assign fin_o      = valid_q[1] & ~valid_q[0];
   assign mismatch_o = (csum_add(sum_q, rdData_i) != expected_i);

endmodule

// File: rtl/bram_stream_loader.sv
// Framed byte-stream loader for the byte-wide block RAM: captures the header,
// writes the payload, then reads the span back and reports done/error status.
module bram_stream_loader
   import bram_loader_pkg::*;
#(
   parameter int AWID = 12,
   parameter int DWID = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      s_data,
   input  logic            s_valid,
   output logic            s_ready,
   output logic [AWID-1:0] ram_addr,
   output logic [DWID-1:0] ram_din,
   output logic            ram_wen,
   input  logic [DWID-1:0] ram_dout,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [1:0]      err_code
);

   if (DWID != 8) begin : gDwidCheck
      $error("bram_stream_loader: DWID must be 8");
   end

   localparam logic [16:0] DEPTH = 17'(1) << AWID;

   state_t          state_q, state_d;
   err_t            errCode_q, errCode_d;
   logic [AWID-1:0] start_q, start_d;
   logic [AWID-1:0] cur_q, cur_d;
   logic [7:0]      lenHi_q, lenHi_d;
   logic [16:0]     lenN_q, lenN_d;
   logic [16:0]     dataCnt_q, dataCnt_d;
   logic [7:0]      sum_q, sum_d;
   logic            busy_q, busy_d;
   logic [AWID-1:0] ramAddr_q, ramAddr_d;
   logic [DWID-1:0] ramDin_q, ramDin_d;
   logic            ramWen_q, ramWen_d;
   logic            accept, inHeader, rbStart;
   logic [AWID-1:0] rbAddr;
   logic            rbBusy, rbMismatch, rbFin;

   assign inHeader = (int'(state_q) < HDR_BYTES);
   assign s_ready  = !rst && (inHeader || state_q == S_DATA || state_q == S_CSUM);
   assign accept   = s_valid && s_ready;

   loader_readback #(.AWID(AWID)) uReadback (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (rbStart),
      .startAddr_i (start_q),
      .count_i     (lenN_q),
      .expected_i  (sum_q),
      .rdData_i    (ram_dout),
      .rdAddr_o    (rbAddr),
      .busy_o      (rbBusy),
      .mismatch_o  (rbMismatch),
      .fin_o       (rbFin)
   );

   always_comb begin
      state_d   = state_q;
      errCode_d = errCode_q;
      start_d   = start_q;
      cur_d     = cur_q;
      lenHi_d   = lenHi_q;
      lenN_d    = lenN_q;
      dataCnt_d = dataCnt_q;
      sum_d     = sum_q;
      busy_d    = busy_q;
      ramAddr_d = ramAddr_q;
      ramDin_d  = ramDin_q;
      ramWen_d  = 1'b0;
      rbStart   = 1'b0;
      unique case (state_q)
         S_HDR0: if (accept) begin
            // Start address is assembled in place; bits above AWID fall off in the casts.
            start_d   = AWID'({s_data, 8'h00});
            busy_d    = 1'b1;
            errCode_d = ERR_NONE;
            sum_d     = '0;
            state_d   = S_HDR1;
         end
         S_HDR1: if (accept) begin
            start_d = start_q | AWID'(s_data);
            state_d = S_HDR2;
         end
         S_HDR2: if (accept) begin
            lenHi_d = s_data;
            state_d = S_HDR3;
         end
         S_HDR3: if (accept) begin
            lenN_d    = {1'b0, lenHi_q, s_data} + 17'd1;
            dataCnt_d = lenN_d;
            cur_d     = start_q;
            if (lenN_d > DEPTH) errCode_d = ERR_LEN;
            state_d   = S_DATA;
         end
         S_DATA: if (accept) begin
            sum_d = csum_add(sum_q, s_data);
            if (errCode_q != ERR_LEN) begin
               ramWen_d  = 1'b1;
               ramAddr_d = cur_q;
               ramDin_d  = DWID'(s_data);
            end
            cur_d     = cur_q + AWID'(1);
            dataCnt_d = dataCnt_q - 17'd1;
            if (dataCnt_q == 17'd1) state_d = S_CSUM;
         end
         S_CSUM: if (accept) begin
            if (errCode_q != ERR_NONE) begin
               state_d = S_DONE;
            end else if (s_data != sum_q) begin
               errCode_d = ERR_CSUM;
               state_d   = S_DONE;
            end else begin
               rbStart = 1'b1;
               state_d = S_VERIFY;
            end
         end
         S_VERIFY: begin
            if (rbBusy) ramAddr_d = rbAddr;
            if (rbFin) begin
               if (rbMismatch) errCode_d = ERR_VERIFY;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_HDR0;
         end
         default: state_d = S_HDR0;
      endcase
   end

   // Reset also squashes a write requested on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_HDR0;
         errCode_q <= ERR_NONE;
         start_q   <= '0;
         cur_q     <= '0;
         lenHi_q   <= '0;
         lenN_q    <= '0;
         dataCnt_q <= '0;
         sum_q     <= '0;
         busy_q    <= 1'b0;
         ramAddr_q <= '0;
         ramDin_q  <= '0;
         ramWen_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         errCode_q <= errCode_d;
         start_q   <= start_d;
         cur_q     <= cur_d;
         lenHi_q   <= lenHi_d;
         lenN_q    <= lenN_d;
         dataCnt_q <= dataCnt_d;
         sum_q     <= sum_d;
         busy_q    <= busy_d;
         ramAddr_q <= ramAddr_d;
         ramDin_q  <= ramDin_d;
         ramWen_q  <= ramWen_d;
      end
   end

   assign ram_addr = ramAddr_q;
   assign ram_din  = ramDin_q;
   assign ram_wen  = ramWen_q;
   assign busy     = busy_q;
   assign done     = (state_q == S_DONE);
   assign err      = (errCode_q != ERR_NONE);
   assign err_code = errCode_q;

endmodule
